// File: rtl/pu_riscv_biu_arbiter_if.sv
// Pipelined BIU handshake bundle: address phase (stb/stb_ack) plus data response (ack/err).
interface pu_riscv_biu_arbiter_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned PLEN = 64
);
    logic            stb;
    logic            stb_ack;
    logic [PLEN-1:0] adri;
    logic [2:0]      size;
    logic [2:0]      typ;
    logic [2:0]      prot;
    logic            lock;
    logic            we;
    logic [XLEN-1:0] d;
    logic [PLEN-1:0] adro;
    logic [XLEN-1:0] q;
    logic            ack;
    logic            err;

    modport master (
        output stb, adri, size, typ, prot, lock, we, d,
        input  stb_ack, adro, q, ack, err
    );

    modport slave (
        input  stb, adri, size, typ, prot, lock, we, d,
        output stb_ack, adro, q, ack, err
    );
endinterface

// File: rtl/pu_riscv_biu_arbiter.sv
// Shares one BIU between the data and instruction ports: round-robin address arbitration
// with stall/lock hold, plus an ownership FIFO that routes each response to its requester.
module pu_riscv_biu_arbiter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned PLEN  = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pu_riscv_biu_arbiter_if.slave  dbiu,
    pu_riscv_biu_arbiter_if.slave  ibiu,
    pu_riscv_biu_arbiter_if.master biu
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [0:0] PORT_D = 1'b0;
    localparam logic [0:0] PORT_I = 1'b1;

    logic            hold_q, hold_d, hold_own_q, hold_own_d;
    logic            lock_q, lock_d, lock_own_q, lock_own_d;
    logic            last_q, last_d;
    logic [PW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q;
    logic [DEPTH-1:0] own_mem;

    logic sel, sel_stb, sel_lock, lock_own_stb;
    logic full, empty, accept, push, pop, head;

    // Stalled address phases and locked sequences pin the mux; otherwise round-robin.
    always_comb begin
        if (hold_q)                sel = hold_own_q;
        else if (lock_q)           sel = lock_own_q;
        else if (last_q == PORT_D) sel = ibiu.stb ? PORT_I : PORT_D;
        else                       sel = dbiu.stb ? PORT_D : PORT_I;
    end

    assign sel_stb      = (sel == PORT_I) ? ibiu.stb  : dbiu.stb;
    assign sel_lock     = (sel == PORT_I) ? ibiu.lock : dbiu.lock;
    assign lock_own_stb = (lock_own_q == PORT_I) ? ibiu.stb : dbiu.stb;

    assign full   = (cnt_q == CW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign accept = biu.stb & biu.stb_ack;
    assign push   = accept;
    assign pop    = (biu.ack | biu.err) & ~empty;
    assign head   = own_mem[rp_q];

    assign biu.stb  = sel_stb & ~full;
    assign biu.adri = (sel == PORT_I) ? ibiu.adri : dbiu.adri;
    assign biu.size = (sel == PORT_I) ? ibiu.size : dbiu.size;
    assign biu.typ  = (sel == PORT_I) ? ibiu.typ  : dbiu.typ;
    assign biu.prot = (sel == PORT_I) ? ibiu.prot : dbiu.prot;
    assign biu.lock = sel_lock;
    assign biu.we   = (sel == PORT_I) ? ibiu.we   : dbiu.we;
    assign biu.d    = (sel == PORT_I) ? ibiu.d    : dbiu.d;

    assign dbiu.stb_ack = accept & (sel == PORT_D);
    assign ibiu.stb_ack = accept & (sel == PORT_I);

    assign dbiu.ack = biu.ack & ~empty & (head == PORT_D);
    assign ibiu.ack = biu.ack & ~empty & (head == PORT_I);
    assign dbiu.err = biu.err & ~empty & (head == PORT_D);
    assign ibiu.err = biu.err & ~empty & (head == PORT_I);

    assign dbiu.adro = biu.adro;
    assign ibiu.adro = biu.adro;
    assign dbiu.q    = biu.q;
    assign ibiu.q    = biu.q;

    // Arbitration state next-value logic.
    always_comb begin
        hold_d     = hold_q;
        hold_own_d = hold_own_q;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        last_d     = last_q;

        if (biu.stb && !biu.stb_ack) begin
            hold_d     = 1'b1;
            hold_own_d = sel;
        end else if (biu.stb_ack || (hold_q && !sel_stb)) begin
            hold_d = 1'b0;
        end

        if (accept) begin
            last_d = sel;
            if (sel_lock) begin
                lock_d     = 1'b1;
                lock_own_d = sel;
            end else if (lock_q && (sel == lock_own_q)) begin
                lock_d = 1'b0;
            end
        end else if (lock_q && !lock_own_stb) begin
            lock_d = 1'b0;
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q     <= 1'b0;
            hold_own_q <= PORT_D;
            lock_q     <= 1'b0;
            lock_own_q <= PORT_D;
            last_q     <= PORT_I;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_own_q <= hold_own_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            last_q     <= last_d;
            if (push) wp_q <= ptr_inc(wp_q);
            if (pop)  rp_q <= ptr_inc(rp_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Owner storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push) own_mem[wp_q] <= sel;
    end
endmodule

// File: tb/tb_pu_riscv_biu_arbiter.sv
// Bench for pu_riscv_biu_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pu_riscv_biu_arbiter;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned PLEN  = 64;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pu_riscv_biu_arbiter_if #(.XLEN(XLEN), .PLEN(PLEN)) d_if ();
    pu_riscv_biu_arbiter_if #(.XLEN(XLEN), .PLEN(PLEN)) i_if ();
    pu_riscv_biu_arbiter_if #(.XLEN(XLEN), .PLEN(PLEN)) b_if ();

    pu_riscv_biu_arbiter #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .dbiu  (d_if),
        .ibiu  (i_if),
        .biu   (b_if)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    bit m_valid = 0;
    bit m_hold, m_hold_own, m_lock, m_lock_own, m_last;
    bit m_own[$];

    function automatic bit req(input bit p);
        return p ? bit'(i_if.stb) : bit'(d_if.stb);
    endfunction

    function automatic bit model_sel();
        bit pref;
        if (m_hold) return m_hold_own;
        if (m_lock) return m_lock_own;
        pref = ~m_last;
        return req(pref) ? pref : ~pref;
    endfunction

    always @(negedge clk) begin
        bit s, e_stb, e_acc, ne, hd, do_pop;
        s      = model_sel();
        e_stb  = req(s) && (m_own.size() < DEPTH);
        e_acc  = e_stb && b_if.stb_ack;
        ne     = m_own.size() > 0;
        hd     = ne ? m_own[0] : 1'b0;
        do_pop = ne && (b_if.ack || b_if.err);
        if (m_valid) begin
            check("biu_stb", 64'(b_if.stb), 64'(e_stb));
            check("biu_adri", b_if.adri, s ? i_if.adri : d_if.adri);
            check("biu_d", b_if.d, s ? i_if.d : d_if.d);
            check("biu_ctl", 64'({b_if.size, b_if.typ, b_if.prot, b_if.lock, b_if.we}),
                  s ? 64'({i_if.size, i_if.typ, i_if.prot, i_if.lock, i_if.we})
                    : 64'({d_if.size, d_if.typ, d_if.prot, d_if.lock, d_if.we}));
            check("stb_ack", 64'({d_if.stb_ack, i_if.stb_ack}), 64'({e_acc && !s, e_acc && s}));
            check("resp", 64'({d_if.ack, i_if.ack, d_if.err, i_if.err}),
                  64'({b_if.ack && ne && !hd, b_if.ack && ne && hd,
                       b_if.err && ne && !hd, b_if.err && ne && hd}));
            check("bcast", 64'({d_if.adro == b_if.adro, i_if.adro == b_if.adro,
                                d_if.q == b_if.q, i_if.q == b_if.q}), 64'hF);
        end
        if (rst) begin
            m_hold = 0; m_lock = 0; m_last = 1; m_hold_own = 0; m_lock_own = 0;
            m_own.delete();
            m_valid = 1;
        end else if (m_valid) begin
            if (e_stb && !b_if.stb_ack) begin m_hold = 1; m_hold_own = s; end
            else if (b_if.stb_ack || (m_hold && !req(m_hold_own))) m_hold = 0;
            if (m_lock && !req(m_lock_own)) m_lock = 0;
            if (e_acc) begin
                m_last = s;
                if (s ? i_if.lock : d_if.lock) begin m_lock = 1; m_lock_own = s; end
                else if (s == m_lock_own) m_lock = 0;
            end
            if (do_pop) void'(m_own.pop_front());
            if (e_acc) m_own.push_back(s);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit ds, input bit is, input logic [63:0] da, input logic [63:0] ia,
                       input bit dl, input bit il, input bit sa, input bit ak, input bit er);
        d_if.stb = ds; d_if.adri = da; d_if.lock = dl;
        i_if.stb = is; i_if.adri = ia; i_if.lock = il;
        d_if.size = 3'($urandom); d_if.typ = 3'($urandom); d_if.prot = 3'($urandom);
        i_if.size = 3'($urandom); i_if.typ = 3'($urandom); i_if.prot = 3'($urandom);
        d_if.we = 1'($urandom); i_if.we = 1'($urandom);
        d_if.d = {$urandom, $urandom}; i_if.d = {$urandom, $urandom};
        b_if.stb_ack = sa; b_if.ack = ak; b_if.err = er;
        b_if.adro = {$urandom, $urandom}; b_if.q = {$urandom, $urandom};
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] DA = 64'h1000;
    localparam logic [63:0] IA = 64'h2000;

    initial begin
        drv(0, 0, DA, IA, 0, 0, 0, 0, 0);
        rst = 1;
        nxt(); nxt();
        rst = 0;

        // Continuous requests from both ports alternate D,I with acks one cycle later.
        for (int k = 0; k < 5; k++) begin
            drv(k < 4, k < 4, DA, IA, 0, 0, k < 4, k > 0, 0);
            @(negedge clk);
            check("alt_dstb_ack", 64'(d_if.stb_ack), 64'(k < 4 && k % 2 == 0));
            check("alt_istb_ack", 64'(i_if.stb_ack), 64'(k < 4 && k % 2 == 1));
            check("alt_dack", 64'(d_if.ack), 64'(k > 0 && k % 2 == 1));
            check("alt_iack", 64'(i_if.ack), 64'(k > 0 && k % 2 == 0));
            nxt();
        end

        // Stalled D address phase holds the mux for three cycles.
        for (int k = 0; k < 3; k++) begin
            drv(1, 1, DA, IA, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("stall_adri", b_if.adri, 64'h1000);
            check("stall_istb_ack", 64'(i_if.stb_ack), 64'd0);
            nxt();
        end
        drv(1, 1, DA, IA, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("stall_dacc", 64'(d_if.stb_ack), 64'd1);
        nxt();
        drv(1, 1, DA, IA, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("stall_iacc", 64'({i_if.stb_ack, d_if.stb_ack}), 64'b10);
        check("stall_iadri", b_if.adri, 64'h2000);
        nxt();
        drv(0, 0, DA, IA, 0, 0, 0, 1, 0); @(negedge clk);
        check("stall_dack", 64'(d_if.ack), 64'd1); nxt();
        drv(0, 0, DA, IA, 0, 0, 0, 1, 0); @(negedge clk);
        check("stall_iack", 64'(i_if.ack), 64'd1); nxt();

        // Full FIFO blocks stb, including on the pop cycle.
        for (int k = 0; k < 6; k++) begin
            drv(1, 0, DA, IA, 0, 0, 1, k == 4, 0);
            @(negedge clk);
            check("full_stb", 64'(b_if.stb), 64'(k < 2 || k == 5));
            nxt();
        end
        for (int k = 0; k < 2; k++) begin
            drv(0, 0, DA, IA, 0, 0, 0, 1, 0); @(negedge clk);
            check("full_drain_dack", 64'(d_if.ack), 64'd1); nxt();
        end

        // Locked D sequence keeps ownership until the unlocked transfer.
        rst = 1; drv(0, 0, DA, IA, 0, 0, 0, 0, 0); nxt(); rst = 0;
        for (int k = 1; k <= 5; k++) begin
            drv(k <= 3, k <= 4, DA, IA, k <= 2, 0, k <= 4, k >= 2, 0);
            @(negedge clk);
            check("lock_grant", 64'({d_if.stb_ack, i_if.stb_ack}),
                  (k <= 3) ? 64'b10 : (k == 4) ? 64'b01 : 64'b00);
            nxt();
        end

        // Error on second of two in-flight transfers (owners I then D).
        drv(0, 1, DA, IA, 0, 0, 1, 0, 0); nxt();
        drv(1, 0, DA, IA, 0, 0, 1, 0, 0); nxt();
        drv(0, 0, DA, IA, 0, 0, 0, 1, 0); @(negedge clk);
        check("err_iack", 64'({i_if.ack, d_if.ack}), 64'b10); nxt();
        drv(0, 0, DA, IA, 0, 0, 0, 0, 1); @(negedge clk);
        check("err_route", 64'({d_if.err, i_if.err}), 64'b10); nxt();
        drv(0, 0, DA, IA, 0, 0, 0, 0, 0); @(negedge clk);
        check("err_count", 64'(dut.cnt_q), 64'd0); nxt();

        // Reset with two in flight; late acks are dropped.
        drv(1, 0, DA, IA, 0, 0, 1, 0, 0); nxt();
        drv(0, 1, DA, IA, 0, 0, 1, 0, 0); nxt();
        rst = 1; drv(0, 0, DA, IA, 0, 0, 0, 0, 0); nxt(); rst = 0;
        for (int k = 0; k < 2; k++) begin
            drv(0, 0, DA, IA, 0, 0, 0, 1, 0); @(negedge clk);
            check("rst_drop", 64'({d_if.ack, i_if.ack}), 64'b00);
            check("rst_count", 64'(dut.cnt_q), 64'd0);
            nxt();
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0);
            nxt();
        end
        rst = 0;
        drv(0, 0, DA, IA, 0, 0, 0, 0, 0);
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
